// File: rtl/run_detect_arb.sv
// Round-robin scheduler that shares one run-detect datapath among NREQ requesters.
// Each job: grant, start pulse carrying the threshold, sample stream, pipeline drain, result.
module run_detect_arb #(
    parameter int NREQ   = 4,
    parameter int DW     = 8,
    parameter int LENW   = 8,
    parameter int CNTW   = 8,
    parameter int DP_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   thr_in,
    input  logic [NREQ*LENW-1:0] len_in,
    input  logic [NREQ*DW-1:0]   smp_in,
    input  logic [NREQ-1:0]      smp_vld,
    output logic [NREQ-1:0]      smp_rdy,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [CNTW-1:0]      result,
    output logic                 busy,
    output logic                 dp_strt,
    output logic [DW-1:0]        dp_sig,
    output logic                 dp_sig_vld,
    input  logic [CNTW-1:0]      dp_nabv
);

    localparam int IW   = $clog2(NREQ);
    localparam int LATW = $clog2(DP_LAT + 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [IW-1:0]   pick;
    logic            found;
    logic [LENW-1:0] rem;
    logic [LATW-1:0] lat;
    logic [NREQ-1:0] idx_oh;
    logic            abort;

    // First requester at or after ptr, wrapping.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        found = 1'b0;
        pick  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign idx_nxt = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    assign idx_oh  = NREQ'(1) << idx;
    assign abort   = !req[idx] && (state inside {START, STREAM, DRAIN});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            rem        <= '0;
            lat        <= '0;
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            smp_rdy    <= '0;
            busy       <= 1'b0;
            dp_strt    <= 1'b0;
            dp_sig     <= '0;
            dp_sig_vld <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the pulse defaults below are overridden later in the block.
            done       <= '0;
            dp_strt    <= 1'b0;
            dp_sig_vld <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                gnt     <= '0;
                smp_rdy <= '0;
                busy    <= 1'b0;
                ptr     <= idx_nxt;
            end else begin
                case (state)
                    IDLE: begin
                        if (found) begin
                            idx     <= pick;
                            rem     <= len_in[int'(pick)*LENW +: LENW];
                            // dp_sig itself holds the latched threshold during START
                            dp_sig  <= thr_in[int'(pick)*DW +: DW];
                            dp_strt <= 1'b1;
                            gnt     <= NREQ'(1) << pick;
                            busy    <= 1'b1;
                            state   <= START;
                        end
                    end
                    START: begin
                        if (rem != '0) begin
                            smp_rdy <= idx_oh;
                            state   <= STREAM;
                        end else begin
                            lat   <= LATW'(DP_LAT);
                            state <= DRAIN;
                        end
                    end
                    STREAM: begin
                        if (smp_vld[idx]) begin
                            dp_sig     <= smp_in[int'(idx)*DW +: DW];
                            dp_sig_vld <= 1'b1;
                            rem        <= rem - 1'b1;
                            if (rem == LENW'(1)) begin
                                smp_rdy <= '0;
                                lat     <= LATW'(DP_LAT);
                                state   <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (lat == LATW'(1)) begin
                            done   <= idx_oh;
                            result <= dp_nabv;
                            state  <= DONE;
                        end else begin
                            lat <= lat - 1'b1;
                        end
                    end
                    DONE: begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= idx_nxt;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
